// File: rtl/store_monitor.sv
// Store-capture FIFO with a pass/fail/timeout verdict FSM watching processor stores.
// A store to CHECK_ADDR decides the verdict; no decision within TIMEOUT cycles gives TIMEOUT.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  stRun      | waiting for a decision store; cycle counter running
//  stPass     | CHECK_ADDR written with CHECK_DATA (terminal until reset)
//  stFail     | CHECK_ADDR written with any other value (terminal until reset)
//  stTimeout  | TIMEOUT cycles elapsed without a decision (terminal until reset)
module store_monitor #(
    parameter int          DEPTH      = 8,
    parameter logic [31:0] CHECK_ADDR = 32'd100,
    parameter logic [31:0] CHECK_DATA = 32'd7,
    parameter logic [15:0] TIMEOUT    = 16'd1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWriteM,
    input  logic [31:0]              DataAdr,
    input  logic [31:0]              WriteData,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic [15:0]              store_cnt,
    output logic [1:0]               verdict
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        stRun     = 2'b00,
        stPass    = 2'b01,
        stFail    = 2'b10,
        stTimeout = 2'b11
    } verdictState;

    verdictState state;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [15:0]   cycleCnt;
    logic [15:0]   cycleNext;
    logic          full;
    logic          doPop;
    logic          doPush;
    logic          doDrop;
    logic          isCheck;

    assign full      = (count == (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rdPtr];
    assign doPop     = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO only drops without one.
    assign doPush    = MemWriteM && (!full || doPop);
    assign doDrop    = MemWriteM && full && !doPop;
    assign isCheck   = MemWriteM && (DataAdr == CHECK_ADDR);
    assign cycleNext = cycleCnt + 16'd1;
    assign verdict   = state;

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= {DataAdr, WriteData};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (doPop && !doPush) begin
                count <= count - 1'b1;
            end
            if (doDrop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
            if (MemWriteM && store_cnt != 16'hFFFF) begin
                store_cnt <= store_cnt + 16'd1;
            end
        end
    end

    // Decision store beats the timeout when both land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= stRun;
            cycleCnt <= '0;
        end else begin
            case (state)
                stRun: begin
                    cycleCnt <= cycleNext;
                    if (isCheck) begin
                        state <= (WriteData == CHECK_DATA) ? stPass : stFail;
                    end else if (cycleNext == TIMEOUT) begin
                        state <= stTimeout;
                    end
                end
                default: begin
                    state    <= state;
                    cycleCnt <= cycleCnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_monitor.sv
// Directed self-checking bench for store_monitor (DEPTH=8, TIMEOUT=20).
module tb_store_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWriteM = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [15:0] store_cnt;
    logic [1:0]  verdict;

    int checks = 0;
    int errors = 0;

    store_monitor #(
        .DEPTH(8),
        .CHECK_ADDR(32'd100),
        .CHECK_DATA(32'd7),
        .TIMEOUT(16'd20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWriteM(MemWriteM),
        .DataAdr(DataAdr),
        .WriteData(WriteData),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(count),
        .overflow(overflow),
        .drop_cnt(drop_cnt),
        .store_cnt(store_cnt),
        .verdict(verdict)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doStore(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        MemWriteM = 1'b1;
        DataAdr   = a;
        WriteData = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
        MemWriteM = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic applyReset();
        MemWriteM = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_fifo: count=%0d out_valid=%0b expected 0/0", count, out_valid);
        end
        checks++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0 || store_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: ovf=%0b drop=%0d store=%0d expected 0/0/0", overflow, drop_cnt, store_cnt);
        end
        checks++;
        if (verdict !== 2'b00) begin
            errors++;
            $display("FAIL reset_verdict: got %b expected 00", verdict);
        end
    endtask

    task automatic test_basic();
        applyReset();
        doStore(32'h60, 32'hA, 1'b0);
        doStore(32'h64, 32'hB, 1'b0);
        checks++;
        if (count !== 4'd2 || out_data !== 64'h000000600000000A) begin
            errors++;
            $display("FAIL basic_two: count=%0d data=%h expected 2 000000600000000a", count, out_data);
        end
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        checks++;
        if (count !== 4'd1 || out_data !== 64'h000000640000000B) begin
            errors++;
            $display("FAIL basic_pop: count=%0d data=%h expected 1 000000640000000b", count, out_data);
        end
        checks++;
        if (store_cnt !== 16'd2) begin
            errors++;
            $display("FAIL basic_store_cnt: got %0d expected 2", store_cnt);
        end
    endtask

    task automatic test_empty_latency();
        applyReset();
        doStore(32'h80, 32'h1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || count !== 4'd1 || out_data !== 64'h0000008000000001) begin
            errors++;
            $display("FAIL empty_push: valid=%0b count=%0d data=%h expected 1 1 0000008000000001", out_valid, count, out_data);
        end
    endtask

    task automatic test_overflow();
        logic [63:0] exp;
        applyReset();
        for (int i = 0; i < 10; i++) doStore(32'h1000 + 4 * i, 32'h100 + i, 1'b0);
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2 || store_cnt !== 16'd10) begin
            errors++;
            $display("FAIL ovf_state: count=%0d ovf=%0b drop=%0d store=%0d expected 8 1 2 10", count, overflow, drop_cnt, store_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp = {32'h1000 + 32'(4 * i), 32'h100 + 32'(i)};
            checks++;
            if (out_data !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: data=%h valid=%0b expected %h 1", i, out_data, out_valid, exp);
            end
            idle(1);
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_empty: count=%0d valid=%0b ovf=%0b expected 0 0 1", count, out_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [63:0] exp;
        applyReset();
        for (int i = 0; i < 8; i++) doStore(32'h300 + 4 * i, 32'(i), 1'b0);
        doStore(32'h400, 32'hAA, 1'b1);
        checks++;
        if (count !== 4'd8 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop: count=%0d drop=%0d ovf=%0b expected 8 0 0", count, drop_cnt, overflow);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 9; i++) begin
            exp = (i == 8) ? {32'h400, 32'hAA} : {32'h300 + 32'(4 * i), 32'(i)};
            checks++;
            if (out_data !== exp) begin
                errors++;
                $display("FAIL full_drain[%0d]: data=%h expected %h", i, out_data, exp);
            end
            idle(1);
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL full_drained: count=%0d expected 0", count);
        end
    endtask

    task automatic test_drop_saturation();
        applyReset();
        for (int i = 0; i < 264; i++) doStore(32'(i), 32'h5000 + i, 1'b0);
        checks++;
        if (drop_cnt !== 8'd255 || store_cnt !== 16'd264 || count !== 4'd8) begin
            errors++;
            $display("FAIL drop_sat: drop=%0d store=%0d count=%0d expected 255 264 8", drop_cnt, store_cnt, count);
        end
        checks++;
        if (out_data !== 64'h0000000000005000) begin
            errors++;
            $display("FAIL drop_sat_head: data=%h expected 0000000000005000", out_data);
        end
    endtask

    task automatic test_verdict();
        applyReset();
        doStore(32'h40, 32'd7, 1'b0);
        checks++;
        if (verdict !== 2'b00) begin
            errors++;
            $display("FAIL verdict_other_addr: got %b expected 00", verdict);
        end
        doStore(32'd100, 32'd7, 1'b0);
        checks++;
        if (verdict !== 2'b01) begin
            errors++;
            $display("FAIL verdict_pass: got %b expected 01", verdict);
        end
        doStore(32'd100, 32'd3, 1'b0);
        idle(30);
        checks++;
        if (verdict !== 2'b01 || count !== 4'd3) begin
            errors++;
            $display("FAIL verdict_pass_hold: verdict=%b count=%0d expected 01 3", verdict, count);
        end

        applyReset();
        doStore(32'd100, 32'd5, 1'b0);
        checks++;
        if (verdict !== 2'b10) begin
            errors++;
            $display("FAIL verdict_fail: got %b expected 10", verdict);
        end

        applyReset();
        idle(19);
        checks++;
        if (verdict !== 2'b00) begin
            errors++;
            $display("FAIL timeout_early: got %b expected 00 after 19 edges", verdict);
        end
        idle(1);
        checks++;
        if (verdict !== 2'b11) begin
            errors++;
            $display("FAIL timeout_fire: got %b expected 11 after 20 edges", verdict);
        end
        doStore(32'd100, 32'd7, 1'b0);
        checks++;
        if (verdict !== 2'b11 || count !== 4'd1) begin
            errors++;
            $display("FAIL timeout_hold: verdict=%b count=%0d expected 11 1", verdict, count);
        end

        applyReset();
        idle(19);
        doStore(32'd100, 32'd7, 1'b0);
        checks++;
        if (verdict !== 2'b01) begin
            errors++;
            $display("FAIL edge20_pass: got %b expected 01", verdict);
        end

        applyReset();
        idle(19);
        doStore(32'd100, 32'd9, 1'b0);
        checks++;
        if (verdict !== 2'b10) begin
            errors++;
            $display("FAIL edge20_fail: got %b expected 10", verdict);
        end
    endtask

    task automatic test_async_reset();
        applyReset();
        for (int i = 0; i < 4; i++) doStore(32'h20 + 4 * i, 32'(i), 1'b0);
        doStore(32'd100, 32'd7, 1'b0);
        checks++;
        if (count !== 4'd5 || verdict !== 2'b01) begin
            errors++;
            $display("FAIL async_setup: count=%0d verdict=%b expected 5 01", count, verdict);
        end
        #2;
        MemWriteM = 1'b1;
        DataAdr   = 32'd100;
        WriteData = 32'd5;
        reset     = 1'b1;
        #1;
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0 ||
            store_cnt !== 16'd0 || verdict !== 2'b00) begin
            errors++;
            $display("FAIL async_clear: count=%0d valid=%0b ovf=%0b drop=%0d store=%0d verdict=%b expected all 0",
                     count, out_valid, overflow, drop_cnt, store_cnt, verdict);
        end
        idle(1);
        reset     = 1'b0;
        MemWriteM = 1'b0;
        idle(1);
        checks++;
        if (count !== 4'd0 || store_cnt !== 16'd0 || verdict !== 2'b00) begin
            errors++;
            $display("FAIL async_ignore: count=%0d store=%0d verdict=%b expected 0 0 00", count, store_cnt, verdict);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_empty_latency();
        test_overflow();
        test_full_push_pop();
        test_drop_saturation();
        test_verdict();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter DEPTH, 8, store-capture FIFO entries (power of two, >=2).
REQ-002 Parameter CHECK_ADDR, 32'd100, address whose store decides pass/fail.
REQ-003 Parameter CHECK_DATA, 32'd7, data value that signals pass.
REQ-004 Parameter TIMEOUT, 16'd1000, cycles after reset with no decision before the TIMEOUT verdict.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 MemWriteM  input  1  processor memory-stage store strobe.
REQ-008 DataAdr  input  32  store byte address.
REQ-009 WriteData  input  32  store data.
REQ-010 out_valid  output  1  FIFO head entry available.
REQ-011 out_ready  input  1  consumer accepts head entry.
REQ-012 out_data  output  64  head entry, {address[63:32], data[31:0]}.
REQ-013 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky flag, a store was dropped.
REQ-015 drop_cnt  output  8  dropped stores, saturating.
REQ-016 store_cnt  output  16  stores observed, saturating.
REQ-017 verdict  output  2  00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT.

Function
REQ-018 Capture: a rising edge with MemWriteM=1 SHALL be one store event; the FIFO SHALL push {DataAdr, WriteData} unless the push is blocked by a full FIFO.
REQ-019 Drain: out_valid SHALL equal (count != 0); a pop SHALL occur on an edge with out_valid=1 and out_ready=1; out_data SHALL be the oldest entry, combinationally from the head.
REQ-020 Ordering: entries SHALL leave in strict arrival order; pointers SHALL wrap modulo DEPTH.
REQ-021 Full with push and pop on the same edge: the pop SHALL free a slot and the push SHALL succeed; count SHALL stay DEPTH; there SHALL be no drop.
REQ-022 Full with push and no pop: the store SHALL be discarded, overflow SHALL set to 1 and stay set, and drop_cnt SHALL increment, saturating at 255.
REQ-023 Empty with push and out_ready=1: there SHALL be no pop because out_valid=0; the push SHALL succeed and out_valid SHALL go high the next cycle (1-cycle latency).
REQ-024 store_cnt SHALL increment on every store event, dropped or not, saturating at 16'hFFFF.
REQ-025 Verdict FSM states: RUN, PASS, FAIL, TIMEOUT.
REQ-026 In RUN, a store event with DataAdr==CHECK_ADDR and WriteData==CHECK_DATA SHALL move the FSM to PASS.
REQ-027 In RUN, a store event with DataAdr==CHECK_ADDR and WriteData!=CHECK_DATA SHALL move the FSM to FAIL.
REQ-028 In RUN, a 16-bit cycle counter SHALL increment each edge; reaching TIMEOUT with no decision SHALL move the FSM to TIMEOUT.
REQ-029 If a decision store arrives on the edge where the counter reaches TIMEOUT, the decision SHALL take priority.
REQ-030 PASS, FAIL and TIMEOUT SHALL be terminal until reset; the cycle counter SHALL freeze in them.
REQ-031 Verdict SHALL be registered, visible the cycle after the deciding edge.
REQ-032 FIFO capture SHALL continue regardless of verdict state.

Reset
REQ-033 Asserting reset SHALL immediately, without a clock, force count=0, out_valid=0, overflow=0, drop_cnt=0, store_cnt=0, verdict=RUN, cycle counter=0, and both pointers=0.
REQ-034 Reset mid-operation SHALL discard all FIFO contents; out_data is don't-care while out_valid=0.
REQ-035 Stores presented while reset=1 SHALL be ignored.

Verification
REQ-036 Store (0x60, 0xA) then (0x64, 0xB), out_ready=0 -> count=2, out_data=0x000000600000000A; pulse out_ready for one edge -> out_data=0x000000640000000B, count=1.
REQ-037 With DEPTH=8 and out_ready=0, apply 10 stores -> count=8, overflow=1, drop_cnt=2, store_cnt=10; the first 8 entries then drain in order.
REQ-038 FIFO full, store with out_ready=1 on the same edge -> count stays 8, drop_cnt unchanged, new entry appears at the tail.
REQ-039 Store (100, 7) -> verdict=01 next cycle; a later store (100, 3) -> verdict stays 01.
REQ-040 Store (100, 5) -> verdict=10; separately, no stores with TIMEOUT=20 -> verdict=11 after 20 edges; decision store on edge 20 -> PASS/FAIL, not 11.
REQ-041 Assert reset asynchronously mid-cycle with count=5 and verdict=01 -> all outputs return to reset values before the next edge; stores during reset are not captured.
